frontend_mem_arbiter: RTL and testbench

Arbitrates the single AXI-lite-style read port of the memory subsystem between the instruction fetch unit (IFU) and the load/store unit (LSU). It sits between the `ifetch` master interface and the shared memory read channel. It keeps one transaction outstanding at a time. It also discards the read response of an IFU transaction that a front-end flush has cancelled.

---
 rtl/frontend_mem_arbiter_pkg.sv | 20 ++
 rtl/frontend_mem_arbiter_arb_pick2.sv | 26 ++
 rtl/frontend_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_frontend_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frontend_mem_arbiter_pkg.sv
// Shared types and widths for the front-end memory read arbiter.
package frontend_mem_arbiter_pkg;

  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_PROT_W = 3;
  localparam int unsigned AXI_RESP_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/frontend_mem_arbiter_arb_pick2.sv
// Combinational 2-way grant selector: LSU-first priority, or round-robin
// (grant the requester that was not granted last) when i_rr_mode is set.
module arb_pick2
  import frontend_mem_arbiter_pkg::*;
(
  input  logic   i_req_ifu,
  input  logic   i_req_lsu,
  input  logic   i_rr_mode,
  input  owner_t i_last,
  output logic   o_gnt_ifu,
  output logic   o_gnt_lsu
);

  always_comb begin
    o_gnt_ifu = 1'b0;
    o_gnt_lsu = 1'b0;
    if (i_req_ifu && i_req_lsu) begin
      if (i_rr_mode && (i_last == OWNER_LSU)) o_gnt_ifu = 1'b1;
      else                                    o_gnt_lsu = 1'b1;
    end else begin
      o_gnt_ifu = i_req_ifu;
      o_gnt_lsu = i_req_lsu;
    end
  end

endmodule

// File: rtl/frontend_mem_arbiter.sv
// IFU/LSU arbiter for the shared memory read port, one transaction in flight.
// FRONTEND_ARB_RR_EN selects round-robin arbitration; default is LSU priority.
module frontend_mem_arbiter
  import frontend_mem_arbiter_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  flush,
  input  logic [AXI_ADDR_W-1:0] IFU_ARADDR,
  input  logic [AXI_PROT_W-1:0] IFU_ARPROT,
  input  logic                  IFU_ARVALID,
  output logic                  IFU_ARREADY,
  output logic [AXI_DATA_W-1:0] IFU_RDATA,
  output logic [AXI_RESP_W-1:0] IFU_RRESP,
  output logic                  IFU_RVALID,
  input  logic                  IFU_RREADY,
  input  logic [AXI_ADDR_W-1:0] LSU_ARADDR,
  input  logic [AXI_PROT_W-1:0] LSU_ARPROT,
  input  logic                  LSU_ARVALID,
  output logic                  LSU_ARREADY,
  output logic [AXI_DATA_W-1:0] LSU_RDATA,
  output logic [AXI_RESP_W-1:0] LSU_RRESP,
  output logic                  LSU_RVALID,
  input  logic                  LSU_RREADY,
  output logic [AXI_ADDR_W-1:0] M_ARADDR,
  output logic [AXI_PROT_W-1:0] M_ARPROT,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [AXI_DATA_W-1:0] M_RDATA,
  input  logic [AXI_RESP_W-1:0] M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  arb_state_t            r_state, w_next_state;
  owner_t                r_owner;
  logic                  r_drop;
  logic [AXI_ADDR_W-1:0] r_araddr;
  logic [AXI_PROT_W-1:0] r_arprot;
  logic                  r_arvalid;
  owner_t                w_last;
  logic                  w_rr_mode;
  logic                  w_idle, w_gnt_ifu, w_gnt_lsu, w_grant;
  logic                  w_ifu_live, w_m_rready;

`ifdef FRONTEND_ARB_RR_EN
  owner_t r_last;
  assign w_last    = r_last;
  assign w_rr_mode = 1'b1;
`else
  assign w_last    = OWNER_IFU;
  assign w_rr_mode = 1'b0;
`endif

  // RSTn gating keeps ARREADY low while reset is held, not just after release.
  assign w_idle  = (r_state == ST_IDLE) && RSTn;
  assign w_grant = w_gnt_ifu | w_gnt_lsu;

  arb_pick2 u_pick (
    .i_req_ifu (w_idle && IFU_ARVALID && !flush),
    .i_req_lsu (w_idle && LSU_ARVALID),
    .i_rr_mode (w_rr_mode),
    .i_last    (w_last),
    .o_gnt_ifu (w_gnt_ifu),
    .o_gnt_lsu (w_gnt_lsu)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_grant)                 w_next_state = ST_ADDR;
      ST_ADDR: if (M_ARREADY)               w_next_state = ST_DATA;
      ST_DATA: if (M_RVALID && w_m_rready)  w_next_state = ST_IDLE;
      default:                              w_next_state = ST_IDLE;
    endcase
  end

  assign w_ifu_live = (r_owner == OWNER_IFU) && !r_drop && !flush;

  always_comb begin
    IFU_ARREADY = w_gnt_ifu;
    LSU_ARREADY = w_gnt_lsu;
    IFU_RVALID  = 1'b0;
    LSU_RVALID  = 1'b0;
    w_m_rready  = 1'b0;
    if (r_state == ST_DATA) begin
      if (r_owner == OWNER_LSU) begin
        LSU_RVALID = M_RVALID;
        w_m_rready = LSU_RREADY;
      end else if (w_ifu_live) begin
        IFU_RVALID = M_RVALID;
        w_m_rready = IFU_RREADY;
      end else begin
        w_m_rready = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_araddr  <= '0;
      r_arprot  <= '0;
      r_arvalid <= 1'b0;
      r_owner   <= OWNER_IFU;
      r_drop    <= 1'b0;
`ifdef FRONTEND_ARB_RR_EN
      r_last    <= OWNER_IFU;
`endif
    end else if (w_grant) begin
      r_araddr  <= w_gnt_lsu ? LSU_ARADDR : IFU_ARADDR;
      r_arprot  <= w_gnt_lsu ? LSU_ARPROT : IFU_ARPROT;
      r_arvalid <= 1'b1;
      r_owner   <= w_gnt_lsu ? OWNER_LSU : OWNER_IFU;
      r_drop    <= 1'b0;
`ifdef FRONTEND_ARB_RR_EN
      r_last    <= w_gnt_lsu ? OWNER_LSU : OWNER_IFU;
`endif
    end else begin
      if ((r_state == ST_ADDR) && M_ARREADY) r_arvalid <= 1'b0;
      // An accepted IFU read cannot be retracted; remember to discard its beat.
      if (flush && (r_owner == OWNER_IFU) && (r_state != ST_IDLE)) r_drop <= 1'b1;
    end
  end

  assign M_ARADDR  = r_araddr;
  assign M_ARPROT  = r_arprot;
  assign M_ARVALID = r_arvalid;
  assign M_RREADY  = w_m_rready;
  assign IFU_RDATA = M_RDATA;
  assign IFU_RRESP = M_RRESP;
  assign LSU_RDATA = M_RDATA;
  assign LSU_RRESP = M_RRESP;

endmodule

// File: tb/tb_frontend_mem_arbiter.sv
// Directed bench for frontend_mem_arbiter: IDLE arbitration table plus
// hand-written multi-cycle sequences (flush, backpressure, reset mid-read).
module tb_frontend_mem_arbiter;

`ifdef FRONTEND_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic        CLK, RSTn, flush;
  logic [63:0] IFU_ARADDR, LSU_ARADDR, M_ARADDR;
  logic [2:0]  IFU_ARPROT, LSU_ARPROT, M_ARPROT;
  logic        IFU_ARVALID, IFU_ARREADY, IFU_RVALID, IFU_RREADY;
  logic        LSU_ARVALID, LSU_ARREADY, LSU_RVALID, LSU_RREADY;
  logic [63:0] IFU_RDATA, LSU_RDATA, M_RDATA;
  logic [1:0]  IFU_RRESP, LSU_RRESP, M_RRESP;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

  int total = 0;
  int bad   = 0;

  frontend_mem_arbiter dut (
    .CLK(CLK), .RSTn(RSTn), .flush(flush),
    .IFU_ARADDR(IFU_ARADDR), .IFU_ARPROT(IFU_ARPROT), .IFU_ARVALID(IFU_ARVALID),
    .IFU_ARREADY(IFU_ARREADY), .IFU_RDATA(IFU_RDATA), .IFU_RRESP(IFU_RRESP),
    .IFU_RVALID(IFU_RVALID), .IFU_RREADY(IFU_RREADY),
    .LSU_ARADDR(LSU_ARADDR), .LSU_ARPROT(LSU_ARPROT), .LSU_ARVALID(LSU_ARVALID),
    .LSU_ARREADY(LSU_ARREADY), .LSU_RDATA(LSU_RDATA), .LSU_RRESP(LSU_RRESP),
    .LSU_RVALID(LSU_RVALID), .LSU_RREADY(LSU_RREADY),
    .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID),
    .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  typedef struct packed {
    logic ifu_v;
    logic lsu_v;
    logic fl;
    logic exp_ifu_rdy;
    logic exp_lsu_rdy;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
  endtask

  // Leaves the DUT in ADDR with IFU_ARVALID dropped.
  task automatic ifu_grant(input string name, input logic [63:0] a);
    IFU_ARADDR  = a;
    IFU_ARVALID = 1'b1;
    settle();
    chk(name, {63'd0, IFU_ARREADY}, 64'd1);
    tick();
    IFU_ARVALID = 1'b0;
  endtask

  // ADDR accepted immediately; leaves the DUT in DATA.
  task automatic addr_ok();
    M_ARREADY = 1'b1;
    tick();
    M_ARREADY = 1'b0;
  endtask

  initial begin
    flush = 0; IFU_ARADDR = '0; IFU_ARPROT = '0; IFU_ARVALID = 0; IFU_RREADY = 0;
    LSU_ARADDR = '0; LSU_ARPROT = '0; LSU_ARVALID = 0; LSU_RREADY = 0;
    M_ARREADY = 0; M_RDATA = '0; M_RRESP = '0; M_RVALID = 0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state, with requests pending during reset
    RSTn = 1'b0; IFU_ARVALID = 1; LSU_ARVALID = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ifu_arready", {63'd0, IFU_ARREADY}, 64'd0);
    chk("rst_lsu_arready", {63'd0, LSU_ARREADY}, 64'd0);
    chk("rst_m_arvalid",   {63'd0, M_ARVALID}, 64'd0);
    chk("rst_m_araddr",    M_ARADDR, 64'd0);
    chk("rst_m_arprot",    {61'd0, M_ARPROT}, 64'd0);
    chk("rst_m_rready",    {63'd0, M_RREADY}, 64'd0);
    IFU_ARVALID = 0; LSU_ARVALID = 0;
    RSTn = 1'b1;

    // IDLE arbitration table; requests dropped before the edge so nothing is granted
    for (int i = 0; i < 8; i++) begin
      tick();
      IFU_ARVALID = vecs[i].ifu_v; LSU_ARVALID = vecs[i].lsu_v; flush = vecs[i].fl;
      settle();
      chk($sformatf("vec%0d_ifu_arready", i), {63'd0, IFU_ARREADY}, {63'd0, vecs[i].exp_ifu_rdy});
      chk($sformatf("vec%0d_lsu_arready", i), {63'd0, LSU_ARREADY}, {63'd0, vecs[i].exp_lsu_rdy});
      IFU_ARVALID = 0; LSU_ARVALID = 0; flush = 0;
    end
    tick();
    chk("table_no_grant", {63'd0, M_ARVALID}, 64'd0);

    // Single IFU read
    IFU_ARADDR = 64'h8000_0000; IFU_ARPROT = 3'b100; IFU_ARVALID = 1;
    settle();
    chk("s1_ifu_arready", {63'd0, IFU_ARREADY}, 64'd1);
    chk("s1_lsu_arready", {63'd0, LSU_ARREADY}, 64'd0);
    tick();
    IFU_ARVALID = 0; M_ARREADY = 1;
    settle();
    chk("s1_m_arvalid", {63'd0, M_ARVALID}, 64'd1);
    chk("s1_m_araddr", M_ARADDR, 64'h8000_0000);
    chk("s1_m_arprot", {61'd0, M_ARPROT}, 64'd4);
    chk("s1_lsu_rvalid_addr", {63'd0, LSU_RVALID}, 64'd0);
    tick();
    M_ARREADY = 0; M_RVALID = 1; M_RDATA = 64'h0000_0013_0000_0093; IFU_RREADY = 1;
    settle();
    chk("s1_ifu_rvalid", {63'd0, IFU_RVALID}, 64'd1);
    chk("s1_ifu_rdata", IFU_RDATA, 64'h0000_0013_0000_0093);
    chk("s1_lsu_rvalid_data", {63'd0, LSU_RVALID}, 64'd0);
    chk("s1_m_rready", {63'd0, M_RREADY}, 64'd1);
    chk("s1_m_arvalid_low", {63'd0, M_ARVALID}, 64'd0);
    tick();
    M_RVALID = 0; IFU_RREADY = 0;
    settle();
    chk("s1_ifu_rvalid_end", {63'd0, IFU_RVALID}, 64'd0);

    // Contention after reset
    do_reset();
    IFU_ARADDR = 64'h2000; LSU_ARADDR = 64'h1000; IFU_ARVALID = 1; LSU_ARVALID = 1;
    settle();
    chk("s2_first_lsu", {63'd0, LSU_ARREADY}, 64'd1);
    chk("s2_first_ifu", {63'd0, IFU_ARREADY}, 64'd0);
    tick();
    M_ARREADY = 1;
    settle();
    chk("s2_addr_no_ifu_rdy", {63'd0, IFU_ARREADY}, 64'd0);
    chk("s2_addr_no_lsu_rdy", {63'd0, LSU_ARREADY}, 64'd0);
    chk("s2_m_araddr", M_ARADDR, 64'h1000);
    tick();
    M_ARREADY = 0; M_RVALID = 1; M_RRESP = 2'b10; LSU_RREADY = 1;
    settle();
    chk("s2_lsu_rvalid", {63'd0, LSU_RVALID}, 64'd1);
    chk("s2_lsu_rresp", {62'd0, LSU_RRESP}, 64'd2);
    chk("s2_ifu_rvalid", {63'd0, IFU_RVALID}, 64'd0);
    tick();
    M_RVALID = 0; M_RRESP = 2'b00;
    settle();
    chk("s2_second_ifu", {63'd0, IFU_ARREADY}, {63'd0, RR});
    chk("s2_second_lsu", {63'd0, LSU_ARREADY}, {63'd0, !RR});
    tick();
    M_ARREADY = 1;
    settle();
    chk("s2_second_addr", M_ARADDR, RR ? 64'h2000 : 64'h1000);
    tick();
    M_ARREADY = 0; M_RVALID = 1; IFU_RREADY = 1;
    tick();
    M_RVALID = 0;
    settle();
    chk("s2_third_lsu", {63'd0, LSU_ARREADY}, 64'd1);
    IFU_ARVALID = 0; LSU_ARVALID = 0; IFU_RREADY = 0; LSU_RREADY = 0;

    // Flush in ADDR with M_ARREADY delayed two cycles
    do_reset();
    ifu_grant("s3_grant", 64'h3000);
    flush = 1;
    settle();
    chk("s3_arvalid_flush", {63'd0, M_ARVALID}, 64'd1);
    tick();
    flush = 0;
    settle();
    chk("s3_arvalid_hold", {63'd0, M_ARVALID}, 64'd1);
    chk("s3_araddr_hold", M_ARADDR, 64'h3000);
    tick();
    M_ARREADY = 1;
    settle();
    chk("s3_arvalid_hs", {63'd0, M_ARVALID}, 64'd1);
    tick();
    M_ARREADY = 0; M_RVALID = 1; M_RDATA = 64'h1111; IFU_RREADY = 0;
    settle();
    chk("s3_drop_rready", {63'd0, M_RREADY}, 64'd1);
    chk("s3_drop_rvalid", {63'd0, IFU_RVALID}, 64'd0);
    tick();
    M_RVALID = 0;
    ifu_grant("s3_back_idle", 64'h3008);
    // Flush coinciding with the response beat
    addr_ok();
    M_RVALID = 1; IFU_RREADY = 1; flush = 1;
    settle();
    chk("s3b_rvalid", {63'd0, IFU_RVALID}, 64'd0);
    chk("s3b_rready", {63'd0, M_RREADY}, 64'd1);
    tick();
    M_RVALID = 0; flush = 0;
    // Drop flag must not leak into the next IFU read
    ifu_grant("s3c_grant", 64'h3010);
    addr_ok();
    M_RVALID = 1; M_RDATA = 64'h2222;
    settle();
    chk("s3c_rvalid", {63'd0, IFU_RVALID}, 64'd1);
    tick();
    M_RVALID = 0; IFU_RREADY = 0;

    // LSU backpressure; flush mid-stall must not affect the LSU
    LSU_ARADDR = 64'h4000; LSU_ARVALID = 1;
    settle();
    chk("s4_grant", {63'd0, LSU_ARREADY}, 64'd1);
    tick();
    LSU_ARVALID = 0;
    addr_ok();
    M_RVALID = 1; M_RDATA = 64'hDEAD_BEEF_0123_4567; LSU_RREADY = 0;
    for (int k = 0; k < 3; k++) begin
      flush = (k == 1);
      settle();
      chk($sformatf("s4_stall%0d_rready", k), {63'd0, M_RREADY}, 64'd0);
      chk($sformatf("s4_stall%0d_rvalid", k), {63'd0, LSU_RVALID}, 64'd1);
      tick();
    end
    flush = 0; LSU_RREADY = 1;
    settle();
    chk("s4_rready", {63'd0, M_RREADY}, 64'd1);
    chk("s4_rdata", LSU_RDATA, 64'hDEAD_BEEF_0123_4567);
    tick();
    M_RVALID = 0; LSU_RREADY = 0;

    // Flush with IFU request in IDLE, LSU idle
    IFU_ARVALID = 1; flush = 1;
    settle();
    chk("s5_ifu_arready", {63'd0, IFU_ARREADY}, 64'd0);
    chk("s5_lsu_arready", {63'd0, LSU_ARREADY}, 64'd0);
    tick();
    chk("s5_stay_idle", {63'd0, M_ARVALID}, 64'd0);
    flush = 0;
    settle();
    chk("s5_idle_grant", {63'd0, IFU_ARREADY}, 64'd1);
    IFU_ARVALID = 0;
    settle();

    // Reset asserted in DATA
    tick();
    ifu_grant("s6_grant", 64'h5000);
    addr_ok();
    M_RVALID = 1; IFU_RREADY = 0; IFU_ARVALID = 1;
    settle();
    chk("s6_in_data", {63'd0, IFU_RVALID}, 64'd1);
    RSTn = 1'b0;
    settle();
    chk("s6_rst_rvalid", {63'd0, IFU_RVALID}, 64'd0);
    chk("s6_rst_rready", {63'd0, M_RREADY}, 64'd0);
    chk("s6_rst_arvalid", {63'd0, M_ARVALID}, 64'd0);
    chk("s6_rst_arready", {63'd0, IFU_ARREADY}, 64'd0);
    chk("s6_rst_araddr", M_ARADDR, 64'd0);
    M_RVALID = 0; IFU_ARVALID = 0;
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    ifu_grant("s6_post_grant", 64'h6000);
    M_ARREADY = 1;
    settle();
    chk("s6_post_arvalid", {63'd0, M_ARVALID}, 64'd1);
    chk("s6_post_araddr", M_ARADDR, 64'h6000);
    tick();
    M_ARREADY = 0; M_RVALID = 1; M_RDATA = 64'h6666; IFU_RREADY = 1;
    settle();
    chk("s6_post_rvalid", {63'd0, IFU_RVALID}, 64'd1);
    chk("s6_post_rdata", IFU_RDATA, 64'h6666);
    tick();
    M_RVALID = 0; IFU_RREADY = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
